// File: rtl/pc_call_stack.sv
// Program counter with a return-address LIFO: increments, jumps PC-relative on BSR
// (pushing pc+1), pops on RET, and freezes completely while HOLD is high.
module pc_call_stack #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                     CLK,
  input  logic                     RESET_n,
  input  logic                     HOLD,
  input  logic                     bsr_det,
  input  logic                     ret_det,
  input  logic [9:0]               relative_jump,
  output logic [ADDR_W-1:0]        pc,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     ovf_err,
  output logic                     udf_err,
  output logic                     conf_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              conf_q, conf_d;
  logic [ADDR_W-1:0] stack_q [DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_jmp;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;
  logic              push_en;
  logic              full;
  logic              empty;

  // Offset is relative to the BSR's own address; the sum wraps at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] rel_target(input logic [ADDR_W-1:0] base,
                                                   input logic signed [9:0] off);
    logic signed [ADDR_W-1:0] off_ext;
    off_ext = off;
    return base + off_ext;
  endfunction

  assign full    = (sp_q == SP_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign pc_jmp  = rel_target(pc_q, relative_jump);
  assign wr_idx  = sp_q[IDX_W-1:0];
  assign top_idx = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    conf_d  = conf_q;
    push_en = 1'b0;
    if (!HOLD) begin
      pc_d = pc_inc;
      if (bsr_det && ret_det) begin
        conf_d = 1'b1;
      end else if (bsr_det) begin
        if (!full) begin
          push_en = 1'b1;
          sp_d    = sp_q + SP_W'(1);
          pc_d    = pc_jmp;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (ret_det) begin
        if (!empty) begin
          pc_d = stack_q[top_idx];
          sp_d = sp_q - SP_W'(1);
        end else begin
          udf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      pc_q   <= ADDR_W'(RESET_PC);
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      conf_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      sp_q   <= sp_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      conf_q <= conf_d;
    end
  end

  // Storage needs no reset: entries above sp are never read.
  always_ff @(posedge CLK) begin
    if (push_en) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign sp          = sp_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;
  assign conf_err    = conf_q;

endmodule
